// File: rtl/mpf_vtp_lookup_tag_mux_if.sv
// Bundle of client-side and service-side lookup request/response signals.
// The mux uses the slave modport; the environment (clients + service) drives via master.
interface mpf_vtp_lookup_tag_mux_if #(
  parameter int N_CHANNELS   = 2,
  parameter int MAX_REQS     = 32,
  parameter int CLI_TAG_BITS = 5,
  parameter int VA_IDX_BITS  = 36,
  parameter int PA_IDX_BITS  = 36
);
  localparam int TAG_W = $clog2(MAX_REQS);

  logic [N_CHANNELS-1:0]              cli_req_valid;
  logic [N_CHANNELS-1:0]              cli_req_rdy;
  logic [N_CHANNELS*VA_IDX_BITS-1:0]  cli_req_page_va;
  logic [N_CHANNELS-1:0]              cli_req_spec;
  logic [N_CHANNELS*CLI_TAG_BITS-1:0] cli_req_tag;

  logic                               svc_req_valid;
  logic                               svc_req_rdy;
  logic [VA_IDX_BITS-1:0]             svc_req_page_va;
  logic                               svc_req_spec;
  logic [TAG_W-1:0]                   svc_req_tag;

  logic                               svc_rsp_valid;
  logic [TAG_W-1:0]                   svc_rsp_tag;
  logic [PA_IDX_BITS-1:0]             svc_rsp_page_pa;
  logic                               svc_rsp_error;
  logic                               svc_rsp_big_page;
  logic                               svc_rsp_may_cache;

  logic [N_CHANNELS-1:0]              cli_rsp_valid;
  logic [CLI_TAG_BITS-1:0]            cli_rsp_tag;
  logic [PA_IDX_BITS-1:0]             cli_rsp_page_pa;
  logic                               cli_rsp_error;
  logic                               cli_rsp_big_page;
  logic                               cli_rsp_may_cache;

  modport slave (
    input  cli_req_valid, cli_req_page_va, cli_req_spec, cli_req_tag, svc_req_rdy,
           svc_rsp_valid, svc_rsp_tag, svc_rsp_page_pa, svc_rsp_error,
           svc_rsp_big_page, svc_rsp_may_cache,
    output cli_req_rdy, svc_req_valid, svc_req_page_va, svc_req_spec, svc_req_tag,
           cli_rsp_valid, cli_rsp_tag, cli_rsp_page_pa, cli_rsp_error,
           cli_rsp_big_page, cli_rsp_may_cache
  );

  modport master (
    output cli_req_valid, cli_req_page_va, cli_req_spec, cli_req_tag, svc_req_rdy,
           svc_rsp_valid, svc_rsp_tag, svc_rsp_page_pa, svc_rsp_error,
           svc_rsp_big_page, svc_rsp_may_cache,
    input  cli_req_rdy, svc_req_valid, svc_req_page_va, svc_req_spec, svc_req_tag,
           cli_rsp_valid, cli_rsp_tag, cli_rsp_page_pa, cli_rsp_error,
           cli_rsp_big_page, cli_rsp_may_cache
  );
endinterface

// File: rtl/mpf_vtp_lookup_tag_mux.sv
// N-channel round-robin front end to the VTP translation service with a MAX_REQS tag pool.
// Optional statistics counters are enabled by defining MPF_VTP_LOOKUP_MUX_STATS_EN.
module mpf_vtp_lookup_tag_mux #(
  parameter int N_CHANNELS   = 2,
  parameter int MAX_REQS     = 32,
  parameter int CLI_TAG_BITS = 5,
  parameter int VA_IDX_BITS  = 36,
  parameter int PA_IDX_BITS  = 36
) (
  input  logic                       clk,
  input  logic                       reset_n,
  mpf_vtp_lookup_tag_mux_if.slave    bus,
  output logic [$clog2(MAX_REQS):0]  outstanding,
  output logic                       err_bad_tag
`ifdef MPF_VTP_LOOKUP_MUX_STATS_EN
  ,
  output logic [31:0]                stat_lookups,
  output logic [31:0]                stat_errors,
  output logic [31:0]                stat_big_pages
`endif
);
  localparam int TAG_W = $clog2(MAX_REQS);
  localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int OUT_W = TAG_W + 1;

  logic [MAX_REQS-1:0]     free_q, free_d;
  logic [CH_W-1:0]         rr_q, rr_d;
  logic [OUT_W-1:0]        outstanding_q, outstanding_d;
  logic                    err_q;
  logic [CH_W-1:0]         tbl_ch_q  [MAX_REQS];
  logic [CLI_TAG_BITS-1:0] tbl_tag_q [MAX_REQS];

  logic                    svc_valid_q, svc_spec_q;
  logic [VA_IDX_BITS-1:0]  svc_va_q;
  logic [TAG_W-1:0]        svc_tag_q;

  logic [N_CHANNELS-1:0]   rsp_valid_q, rsp_oh;
  logic [CLI_TAG_BITS-1:0] rsp_tag_q;
  logic [PA_IDX_BITS-1:0]  rsp_pa_q;
  logic                    rsp_err_q, rsp_big_q, rsp_mc_q;

  logic                    gnt_found, gnt, can_load, any_free, rsp_hit, rsp_bad;
  logic [CH_W-1:0]         gnt_idx;
  logic [VA_IDX_BITS-1:0]  gnt_va;
  logic                    gnt_spec;
  logic [CLI_TAG_BITS-1:0] gnt_ctag;
  logic [TAG_W-1:0]        alloc_tag;
  logic [N_CHANNELS-1:0]   req_rdy;

  // Round-robin: first pass from rr_q upward, second pass wraps to the low channels.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_va    = '0;
    gnt_spec  = 1'b0;
    gnt_ctag  = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (!gnt_found && bus.cli_req_valid[c] && (c >= int'(rr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(c);
        gnt_va    = bus.cli_req_page_va[c*VA_IDX_BITS +: VA_IDX_BITS];
        gnt_spec  = bus.cli_req_spec[c];
        gnt_ctag  = bus.cli_req_tag[c*CLI_TAG_BITS +: CLI_TAG_BITS];
      end
    end
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (!gnt_found && bus.cli_req_valid[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(c);
        gnt_va    = bus.cli_req_page_va[c*VA_IDX_BITS +: VA_IDX_BITS];
        gnt_spec  = bus.cli_req_spec[c];
        gnt_ctag  = bus.cli_req_tag[c*CLI_TAG_BITS +: CLI_TAG_BITS];
      end
    end
  end

  always_comb begin
    alloc_tag = '0;
    for (int t = MAX_REQS - 1; t >= 0; t--) begin
      if (free_q[t]) alloc_tag = TAG_W'(t);
    end
  end

  assign any_free = |free_q;
  assign can_load = !svc_valid_q || bus.svc_req_rdy;
  assign gnt      = gnt_found && can_load && any_free;
  assign rsp_hit  = bus.svc_rsp_valid && !free_q[bus.svc_rsp_tag];
  assign rsp_bad  = bus.svc_rsp_valid &&  free_q[bus.svc_rsp_tag];

  always_comb begin
    req_rdy = '0;
    if (gnt) req_rdy[gnt_idx] = 1'b1;
    rsp_oh = '0;
    if (rsp_hit) rsp_oh[tbl_ch_q[bus.svc_rsp_tag]] = 1'b1;
  end

  // Allocation and release may hit different tags in the same cycle; both apply.
  always_comb begin
    free_d = free_q;
    rr_d   = rr_q;
    if (gnt) begin
      free_d[alloc_tag] = 1'b0;
      rr_d = (gnt_idx == CH_W'(N_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (rsp_hit) free_d[bus.svc_rsp_tag] = 1'b1;
    outstanding_d = OUT_W'(MAX_REQS);
    for (int t = 0; t < MAX_REQS; t++) begin
      outstanding_d = outstanding_d - OUT_W'(free_d[t]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      free_q        <= '1;
      rr_q          <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      svc_valid_q   <= 1'b0;
      svc_va_q      <= '0;
      svc_spec_q    <= 1'b0;
      svc_tag_q     <= '0;
      rsp_valid_q   <= '0;
      rsp_tag_q     <= '0;
      rsp_pa_q      <= '0;
      rsp_err_q     <= 1'b0;
      rsp_big_q     <= 1'b0;
      rsp_mc_q      <= 1'b0;
    end else begin
      free_q        <= free_d;
      rr_q          <= rr_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_q | rsp_bad;
      if (gnt) begin
        svc_valid_q <= 1'b1;
        svc_va_q    <= gnt_va;
        svc_spec_q  <= gnt_spec;
        svc_tag_q   <= alloc_tag;
      end else if (bus.svc_req_rdy) begin
        svc_valid_q <= 1'b0;
      end
      rsp_valid_q <= rsp_oh;
      if (rsp_hit) begin
        rsp_tag_q <= tbl_tag_q[bus.svc_rsp_tag];
        rsp_pa_q  <= bus.svc_rsp_page_pa;
        rsp_err_q <= bus.svc_rsp_error;
        rsp_big_q <= bus.svc_rsp_big_page;
        rsp_mc_q  <= bus.svc_rsp_may_cache;
      end
    end
  end

  // NOTE: the tag table needs no reset; an entry is only read while its free bit is clear.
  always_ff @(posedge clk) begin
    if (gnt) begin
      tbl_ch_q[alloc_tag]  <= gnt_idx;
      tbl_tag_q[alloc_tag] <= gnt_ctag;
    end
  end

`ifdef MPF_VTP_LOOKUP_MUX_STATS_EN
  logic [31:0] lookups_q, errors_q, big_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lookups_q <= '0;
      errors_q  <= '0;
      big_q     <= '0;
    end else begin
      if (svc_valid_q && bus.svc_req_rdy && !(&lookups_q)) lookups_q <= lookups_q + 1'b1;
      if (rsp_hit && bus.svc_rsp_error && !(&errors_q))   errors_q  <= errors_q + 1'b1;
      if (rsp_hit && bus.svc_rsp_big_page && !(&big_q))   big_q     <= big_q + 1'b1;
    end
  end
  assign stat_lookups   = lookups_q;
  assign stat_errors    = errors_q;
  assign stat_big_pages = big_q;
`endif

  assign bus.cli_req_rdy       = req_rdy;
  assign bus.svc_req_valid     = svc_valid_q;
  assign bus.svc_req_page_va   = svc_va_q;
  assign bus.svc_req_spec      = svc_spec_q;
  assign bus.svc_req_tag       = svc_tag_q;
  assign bus.cli_rsp_valid     = rsp_valid_q;
  assign bus.cli_rsp_tag       = rsp_tag_q;
  assign bus.cli_rsp_page_pa   = rsp_pa_q;
  assign bus.cli_rsp_error     = rsp_err_q;
  assign bus.cli_rsp_big_page  = rsp_big_q;
  assign bus.cli_rsp_may_cache = rsp_mc_q;
  assign outstanding           = outstanding_q;
  assign err_bad_tag           = err_q;
endmodule

// File: doc/mpf_vtp_lookup_tag_mux.md
Name: mpf_vtp_lookup_tag_mux

Overview:
Parametrised N-channel front end to the shared VTP translation service. It arbitrates 4KB-page lookup requests from N_CHANNELS VTP ports and allocates a service tag for each one from a pool of MAX_REQS tags, which replaces the fixed 32-entry limit. The service returns responses out of order; the block routes each one back to its originating channel with that channel's own tag restored. It sits between the per-port VTP pipelines and the single translation service/TLB.

Parameters:
N_CHANNELS, 2, number of client VTP ports (1..16)
MAX_REQS, 32, service tags in flight (power of 2, 2..256)
CLI_TAG_BITS, 5, client-side tag width
VA_IDX_BITS, 36, 4KB virtual page index width
PA_IDX_BITS, 36, 4KB physical page index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cli_req_valid  in  N_CHANNELS  per-channel request valid
cli_req_rdy  out  N_CHANNELS  per-channel accept (combinational grant)
cli_req_page_va  in  N_CHANNELS*VA_IDX_BITS  per-channel virtual page index
cli_req_spec  in  N_CHANNELS  speculative flag
cli_req_tag  in  N_CHANNELS*CLI_TAG_BITS  client tag
svc_req_valid  out  1  request to service
svc_req_rdy  in  1  service accept
svc_req_page_va  out  VA_IDX_BITS  forwarded page index
svc_req_spec  out  1  forwarded speculative flag
svc_req_tag  out  $clog2(MAX_REQS)  allocated service tag
svc_rsp_valid  in  1  service response valid (no backpressure)
svc_rsp_tag  in  $clog2(MAX_REQS)  response tag
svc_rsp_page_pa  in  PA_IDX_BITS  translated page
svc_rsp_error, svc_rsp_big_page, svc_rsp_may_cache  in  1 each  response flags
cli_rsp_valid  out  N_CHANNELS  one-hot response strobe
cli_rsp_tag  out  CLI_TAG_BITS  restored client tag (shared by all channels)
cli_rsp_page_pa  out  PA_IDX_BITS  translated page (shared)
cli_rsp_error, cli_rsp_big_page, cli_rsp_may_cache  out  1 each  flags (shared)
outstanding  out  $clog2(MAX_REQS)+1  tags currently allocated
err_bad_tag  out  1  sticky: response arrived on an unallocated tag

Behaviour:
- Reset: all outputs 0; free bitmap all ones; round-robin pointer 0; sticky error cleared. Reset may assert mid-operation: in-flight state is discarded and late service responses are then flagged as bad-tag.
- Output register: svc_req_* is one register stage that holds until svc_req_valid && svc_req_rdy. It may be loaded in the same cycle it drains.
- Grant: exactly one channel per cycle, round-robin starting at the channel after the last winner. A grant requires a free tag and the output register empty or draining.
- cli_req_rdy[i] is 1 only for the granted channel. Accepting a request loads the output register and allocates the lowest-numbered free tag. The tag table records {channel, cli_tag} for that tag.
- Full (no free tag): all cli_req_rdy = 0, and no round-robin pointer update.
- Response path is one cycle latency: svc_rsp_valid at cycle T drives cli_rsp_valid one-hot to the recorded channel at T+1, with the recorded client tag and the registered PA/flags. The tag returns to the free pool at T+1 and can be re-allocated from T+1 onward.
- Simultaneous allocate and free in one cycle: both take effect; outstanding is unchanged.
- Unallocated tag response: cli_rsp_valid stays 0, err_bad_tag sets (cleared only by reset), and there is no bitmap change.
- outstanding = MAX_REQS minus the popcount of the free bitmap, registered. Widths are exact, with no truncation.

Optional Feature:
MPF_VTP_LOOKUP_MUX_STATS_EN
- Defined: adds output stat_lookups (32b), which counts svc_req handshakes.
- Defined: adds output stat_errors (32b), which counts routed responses with error=1.
- Defined: adds output stat_big_pages (32b), which counts routed responses with big_page=1.
- Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with ch0 and ch1 valid every cycle and svc_req_rdy=1 -> grants alternate 0,1,0,1; svc_req_tag = 0,1,2,3.
- MAX_REQS=4, no responses, 6 requests -> 4 issued, then cli_req_rdy=0 and outstanding=4. Response on tag 2 -> tag 2 is re-issued on the next grant, one cycle after the response.
- Out-of-order responses: tags 3,0 arrive while ch1 holds tag 3 (cli_tag 7) and ch0 holds tag 0 (cli_tag 5) -> cli_rsp_valid=2'b10 with tag 7, then 2'b01 with tag 5, each at latency 1, with PA and flags passed through.
- svc_req_rdy low for 5 cycles -> svc_req_* stable; no further grants; exactly one tag allocated.
- Response on a never-allocated tag 9 -> no cli_rsp_valid and err_bad_tag=1; a later reset clears it.
- STATS_EN build with 3 lookups, one response with error=1 and one with big_page=1 -> stat_lookups=3, stat_errors=1, stat_big_pages=1.
